// File: rtl/data_mem.sv
// Word-organised data memory for the single-cycle datapath: clocked byte-lane
// stores with a trace line per committed store, combinational extended loads.
module data_mem #(
    parameter int unsigned WORDS = 3072,
    parameter int unsigned AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic [1:0]  st_type,
    input  logic [2:0]  ld_type,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int unsigned XW = 32;

    localparam logic [1:0] ST_SW  = 2'd0;
    localparam logic [1:0] ST_SH  = 2'd1;
    localparam logic [1:0] ST_SB  = 2'd2;
    localparam logic [1:0] ST_RSV = 2'd3;

    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    logic [XW-1:0] r_mem [WORDS];

    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_oor;
    logic          w_mis;
    logic          w_we;
    logic [XW-1:0] w_word;
    logic [15:0]   w_half;
    logic [7:0]    w_byte;
    logic [XW-1:0] w_load;
    logic [XW-1:0] w_merged;

    assign w_idx  = addr[AW+1:2];
    assign w_lane = addr[1:0];
    // Range check on the full word address so high bits never alias into the array
    assign w_oor  = ({2'b00, addr[31:2]} >= XW'(WORDS));

    // Alignment is judged by the store type on writes, by the load type otherwise
    always_comb begin
        w_mis = 1'b0;
        if (mem_write) begin
            case (st_type)
                ST_SW:   w_mis = |w_lane;
                ST_SH:   w_mis = w_lane[0];
                default: w_mis = 1'b0;
            endcase
        end else begin
            case (ld_type)
                LD_LH, LD_LHU: w_mis = w_lane[0];
                LD_LB, LD_LBU: w_mis = 1'b0;
                default:       w_mis = |w_lane;
            endcase
        end
    end

    assign addr_err = w_oor | w_mis;
    assign w_word   = w_oor ? '0 : r_mem[w_idx];
    assign w_half   = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_lane)
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    always_comb begin
        w_load = w_word;
        case (ld_type)
            LD_LH:   w_load = {{16{w_half[15]}}, w_half};
            LD_LHU:  w_load = {16'h0000, w_half};
            LD_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  w_load = {24'h000000, w_byte};
            default: w_load = w_word;
        endcase
    end

    assign rdata = addr_err ? '0 : w_load;

    // Merge new data into the addressed lanes of the current word
    always_comb begin
        w_merged = w_word;
        case (st_type)
            ST_SW: w_merged = wdata;
            ST_SH: begin
                if (w_lane[1]) w_merged[31:16] = wdata[15:0];
                else           w_merged[15:0]  = wdata[15:0];
            end
            ST_SB: begin
                case (w_lane)
                    2'd1:    w_merged[15:8]  = wdata[7:0];
                    2'd2:    w_merged[23:16] = wdata[7:0];
                    2'd3:    w_merged[31:24] = wdata[7:0];
                    default: w_merged[7:0]   = wdata[7:0];
                endcase
            end
            default: w_merged = w_word;
        endcase
    end

    assign w_we = mem_write && !addr_err && (st_type != ST_RSV);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[w_idx] <= w_merged;
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, w_merged);
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: directed scenarios plus a byte-level model sweep.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic [1:0]  st_type;
    logic [2:0]  ld_type;
    logic [31:0] rdata;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  st;
        logic [2:0]  ld;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        err;
    } step_t;

    logic [7:0] mb [int];

    always #5 clk = ~clk;

    data_mem dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .addr     (addr),
        .wdata    (wdata),
        .mem_write(mem_write),
        .st_type  (st_type),
        .ld_type  (ld_type),
        .rdata    (rdata),
        .addr_err (addr_err)
    );

    task automatic drive(input step_t s, input logic [31:0] p);
        @(negedge clk);
        reset     = s.rst;
        mem_write = s.we;
        st_type   = s.st;
        ld_type   = s.ld;
        addr      = s.a;
        wdata     = s.d;
        pc        = p;
    endtask

    task automatic test_reset();
        exp_t  e;
        step_t t[5] = '{
            '{1'b1, 1'b0, 2'd0, 3'd0, 32'h0000_0000, 32'h0,         32'h0, 1'b0},
            '{1'b1, 1'b1, 2'd0, 3'd0, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h0000_0010, 32'h0,         32'h0, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h0000_0000, 32'h0,         32'h0, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h0000_2FFC, 32'h0,         32'h0, 1'b0}
        };
        foreach (t[i]) begin
            drive(t[i], 32'h0000_0100 + 32'(i * 4));
            if (t[i].rst) continue;
            q.push_back('{t[i].exp, t[i].err});
            #1;
            e = q.pop_front();
            total++;
            if (rdata !== e.data) begin
                bad++;
                $display("FAIL reset[%0d] rdata: got %h want %h", i, rdata, e.data);
            end
            total++;
            if (addr_err !== e.err) begin
                bad++;
                $display("FAIL reset[%0d] addr_err: got %b want %b", i, addr_err, e.err);
            end
        end
    endtask

    task automatic test_store_load();
        exp_t  e;
        step_t t[12] = '{
            '{1'b0, 1'b1, 2'd0, 3'd0, 32'h8, 32'h12345678, 32'h00000000, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h8, 32'h0,        32'h12345678, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd3, 32'h8, 32'h0,        32'h00000078, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd3, 32'hB, 32'h0,        32'h00000012, 1'b0},
            '{1'b0, 1'b1, 2'd2, 3'd3, 32'h9, 32'hFFFFFF80, 32'h00000056, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h8, 32'h0,        32'h12348078, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd3, 32'h9, 32'h0,        32'hFFFFFF80, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd4, 32'h9, 32'h0,        32'h00000080, 1'b0},
            '{1'b0, 1'b1, 2'd1, 3'd2, 32'hA, 32'h0000ABCD, 32'h00001234, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h8, 32'h0,        32'hABCD8078, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd1, 32'hA, 32'h0,        32'hFFFFABCD, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd2, 32'hA, 32'h0,        32'h0000ABCD, 1'b0}
        };
        foreach (t[i]) begin
            drive(t[i], (i == 0) ? 32'h0000_3000 : 32'h0000_3000 + 32'(i * 4));
            q.push_back('{t[i].exp, t[i].err});
            #1;
            e = q.pop_front();
            total++;
            if (rdata !== e.data) begin
                bad++;
                $display("FAIL store_load[%0d] rdata: got %h want %h", i, rdata, e.data);
            end
            total++;
            if (addr_err !== e.err) begin
                bad++;
                $display("FAIL store_load[%0d] addr_err: got %b want %b", i, addr_err, e.err);
            end
        end
    endtask

    task automatic test_errors();
        exp_t  e;
        step_t t[14] = '{
            '{1'b0, 1'b1, 2'd0, 3'd0, 32'h6,         32'hFFFFFFFF, 32'h0,        1'b1},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h4,         32'h0,        32'h0,        1'b0},
            '{1'b0, 1'b1, 2'd1, 3'd0, 32'h5,         32'hFFFFFFFF, 32'h0,        1'b1},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h4,         32'h0,        32'h0,        1'b0},
            '{1'b0, 1'b1, 2'd0, 3'd0, 32'h3000,      32'hFFFFFFFF, 32'h0,        1'b1},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h3000,      32'h0,        32'h0,        1'b1},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h2FFC,      32'h0,        32'h0,        1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h0,         32'h0,        32'h0,        1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h80000008,  32'h0,        32'h0,        1'b1},
            '{1'b0, 1'b0, 2'd0, 3'd1, 32'h9,         32'h0,        32'h0,        1'b1},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'hA,         32'h0,        32'h0,        1'b1},
            '{1'b0, 1'b0, 2'd0, 3'd6, 32'h8,         32'h0,        32'hABCD8078, 1'b0},
            '{1'b0, 1'b1, 2'd3, 3'd0, 32'h8,         32'h11111111, 32'hABCD8078, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h8,         32'h0,        32'hABCD8078, 1'b0}
        };
        foreach (t[i]) begin
            drive(t[i], 32'h0000_4000 + 32'(i * 4));
            q.push_back('{t[i].exp, t[i].err});
            #1;
            e = q.pop_front();
            total++;
            if (rdata !== e.data) begin
                bad++;
                $display("FAIL errors[%0d] rdata: got %h want %h", i, rdata, e.data);
            end
            total++;
            if (addr_err !== e.err) begin
                bad++;
                $display("FAIL errors[%0d] addr_err: got %b want %b", i, addr_err, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t  e;
        step_t t[6] = '{
            '{1'b0, 1'b1, 2'd0, 3'd0, 32'h20, 32'h00000001, 32'h0,        1'b0},
            '{1'b0, 1'b1, 2'd0, 3'd0, 32'h20, 32'h00000002, 32'h00000001, 1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h20, 32'h0,        32'h00000002, 1'b0},
            '{1'b1, 1'b0, 2'd0, 3'd0, 32'h20, 32'h0,        32'h0,        1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h20, 32'h0,        32'h0,        1'b0},
            '{1'b0, 1'b0, 2'd0, 3'd0, 32'h8,  32'h0,        32'h0,        1'b0}
        };
        foreach (t[i]) begin
            drive(t[i], 32'h0000_5000 + 32'(i * 4));
            if (t[i].rst) continue;
            q.push_back('{t[i].exp, t[i].err});
            #1;
            e = q.pop_front();
            total++;
            if (rdata !== e.data) begin
                bad++;
                $display("FAIL back_to_back[%0d] rdata: got %h want %h", i, rdata, e.data);
            end
            total++;
            if (addr_err !== e.err) begin
                bad++;
                $display("FAIL back_to_back[%0d] addr_err: got %b want %b", i, addr_err, e.err);
            end
        end
    endtask

    function automatic logic [7:0] mrd(input logic [31:0] a);
        return mb.exists(int'(a)) ? mb[int'(a)] : 8'h00;
    endfunction

    // Random mix checked against a byte-addressed reference memory
    task automatic test_random();
        exp_t        e;
        step_t       s;
        logic [31:0] w;
        logic [31:0] aw;
        logic [15:0] h;
        logic [7:0]  b;
        logic        oor;
        logic        mis;
        s = '{1'b1, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0};
        drive(s, 32'h0);
        mb.delete();
        for (int n = 0; n < 120; n++) begin
            s.rst = 1'b0;
            s.we  = 1'($urandom_range(0, 1));
            s.st  = 2'($urandom_range(0, 3));
            s.ld  = 3'($urandom_range(0, 7));
            s.a   = ($urandom_range(0, 3) == 0) ? 32'h2FF0 + 32'($urandom_range(0, 31))
                                                : 32'($urandom_range(0, 63));
            s.d   = $urandom;
            aw    = {s.a[31:2], 2'b00};
            oor   = (s.a >= 32'h3000);
            if (s.we) mis = (s.st == 2'd0) ? (s.a[1:0] != 2'b00) : (s.st == 2'd1) ? s.a[0] : 1'b0;
            else if (s.ld == 3'd1 || s.ld == 3'd2) mis = s.a[0];
            else if (s.ld == 3'd3 || s.ld == 3'd4) mis = 1'b0;
            else mis = (s.a[1:0] != 2'b00);
            w = {mrd(aw + 3), mrd(aw + 2), mrd(aw + 1), mrd(aw)};
            h = {mrd(aw + (s.a[1] ? 32'd3 : 32'd1)), mrd(aw + (s.a[1] ? 32'd2 : 32'd0))};
            b = mrd(s.a);
            case (s.ld)
                3'd1:    s.exp = {{16{h[15]}}, h};
                3'd2:    s.exp = {16'h0, h};
                3'd3:    s.exp = {{24{b[7]}}, b};
                3'd4:    s.exp = {24'h0, b};
                default: s.exp = w;
            endcase
            s.err = oor | mis;
            if (s.err) s.exp = 32'h0;
            drive(s, 32'h0000_6000 + 32'(n * 4));
            q.push_back('{s.exp, s.err});
            #1;
            e = q.pop_front();
            total++;
            if (rdata !== e.data) begin
                bad++;
                $display("FAIL random[%0d] rdata: got %h want %h", n, rdata, e.data);
            end
            total++;
            if (addr_err !== e.err) begin
                bad++;
                $display("FAIL random[%0d] addr_err: got %b want %b", n, addr_err, e.err);
            end
            if (s.we && !s.err && s.st != 2'd3) begin
                case (s.st)
                    2'd0: begin
                        mb[int'(aw)]     = s.d[7:0];
                        mb[int'(aw + 1)] = s.d[15:8];
                        mb[int'(aw + 2)] = s.d[23:16];
                        mb[int'(aw + 3)] = s.d[31:24];
                    end
                    2'd1: begin
                        mb[int'(s.a)]     = s.d[7:0];
                        mb[int'(s.a + 1)] = s.d[15:8];
                    end
                    default: mb[int'(s.a)] = s.d[7:0];
                endcase
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        mem_write = 1'b0;
        st_type   = 2'd0;
        ld_type   = 3'd0;
        addr      = 32'h0;
        wdata     = 32'h0;
        pc        = 32'h0;
        test_reset();
        test_store_load();
        test_errors();
        test_back_to_back();
        test_random();
        @(negedge clk);
        mem_write = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised data memory for the single-cycle datapath.
- Sits directly downstream of the ALU: the ALU result is the byte address; the rt register value is the store data.
- Stores are performed on the clock edge with byte-lane merge for sw/sh/sb; loads are combinational with extension for lw/lh/lhu/lb/lbu.
- Every committed store prints one trace line used for grading against the reference simulator.

Parameters:
- WORDS, 3072, number of 32-bit words (12 KiB).
- AW, 12, word-index width; must satisfy 2**AW >= WORDS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears every word.
- pc  input  32  PC of the instruction in flight; used only in the trace line.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data (rt).
- mem_write  input  1  store enable for this cycle.
- st_type  input  2  0=sw, 1=sh, 2=sb, 3=reserved (no write).
- ld_type  input  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu, others read as lw.
- rdata  output  32  extended load result.
- addr_err  output  1  combinational: current access is misaligned or out of range.

Behaviour:
- Storage: mem[0..WORDS-1], 32 bits each. Word index = addr[AW+1:2]; lane = addr[1:0].
- Out of range: addr[31:2] >= WORDS.
- Misaligned access:
  - sw or lw with lane != 0.
  - sh, lh or lhu with lane[0] != 0.
  - byte accesses are never misaligned.
- addr_err:
  - asserted when (mem_write or load-relevant access) is misaligned or out of range.
  - loads are always considered relevant; i.e. addr_err evaluates the ld_type checks whenever mem_write = 0, and the st_type checks when mem_write = 1.
  - purely combinational; no latency.
- Reset:
  - at a rising edge with reset = 1, every word becomes 0x00000000.
  - no store occurs and no trace line is printed, even if mem_write = 1 (reset wins).
  - reset mid-program simply zeroes memory; the cycle after reset behaves normally.
  - rdata is therefore 0 for every address after reset.
- Store (rising edge, reset = 0, mem_write = 1, addr_err = 0, st_type != 3):
  - sw: mem[idx] <= wdata.
  - sh: writes wdata[15:0] into half lane[1] (bits 15:0 if lane[1] = 0, else 31:16); other half is kept.
  - sb: writes wdata[7:0] into byte lane; other three bytes are kept.
  - Trace, same edge: $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word), where merged_word is the full 32-bit value written.
  - A store is printed even when the merged word equals the old contents.
- Store suppressed (addr_err = 1 or st_type = 3): memory is unchanged and no trace line is printed.
- Load (combinational, from current array contents):
  - w = mem[idx].
  - lw: w.
  - lh: sign-extend the selected half.
  - lhu: zero-extend the selected half.
  - lb: sign-extend byte lane.
  - lbu: zero-extend byte lane.
  - If addr_err = 1 or out of range, rdata = 0.
- Read-during-write at the same address: before the edge rdata shows the old word; after the edge it shows the merged word.
- Width rules:
  - Upper address bits beyond the range check are ignored only after the range check passes.
  - No wrap-around: index WORDS and above is rejected, never aliased.
- Single port: at most one access per cycle. A cycle with mem_write = 1 still drives rdata from the pre-edge contents.

Test Plan:
- Reset then lw at addr 0x0, 0x2FFC → rdata = 0x00000000, addr_err = 0; assert reset alongside sw 0x10 = 0xDEADBEEF → no trace line, mem[4] stays 0.
- sw 0x12345678 at 0x8, pc = 0x3000 → trace "@00003000: *00000008 <= 12345678"; then lw 0x8 → 0x12345678, lb 0x8 → 0x00000078, lb 0xB → 0x00000012.
- With 0x12345678 at 0x8: sb wdata = 0xFFFFFF80 at 0x9 → word 0x12348078, traced; lb 0x9 → 0xFFFFFF80, lbu 0x9 → 0x00000080.
- sh wdata = 0x0000ABCD at 0xA over 0x12348078 → 0xABCD8078; lh 0xA → 0xFFFFABCD, lhu 0xA → 0x0000ABCD.
- Misaligned and out-of-range stores:
  - sw at 0x6 → addr_err = 1, no write, no trace.
  - sh at 0x5 → addr_err = 1, no write, no trace.
  - sw at 0x3000 (index 3072) → addr_err = 1, rdata = 0, memory unchanged.
- Back-to-back sw 0x1 then sw 0x2 to 0x20 on consecutive edges → two trace lines in order; lw 0x20 before the second edge returns 0x1 and after it returns 0x2.
